// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier (round-to-nearest-even, FTZ, valid/ready with global stall).
// Define FP_MULT_FLAGS_EN to add the per-result {invalid, overflow, underflow, inexact} flags port.
module fp_mult_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int W     = EXP_W + MAN_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] float_a,
   input  logic [W-1:0] float_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] product
`ifdef FP_MULT_FLAGS_EN
   ,
   output logic [3:0]   flags
`endif
);

   localparam int EW2 = EXP_W + 2;
   localparam int PW  = 2 * MAN_W + 2;
   localparam logic signed [EW2-1:0] BIAS    = EW2'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

   function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] man,
                                                input logic             guard,
                                                input logic             sticky);
      logic inc;
      inc = guard & (sticky | man[0]);
      return {1'b0, man} + {{MAN_W{1'b0}}, inc};
   endfunction

   logic out_valid_q, s1_vld_q, s2_vld_q;
   logic [W-1:0] product_q, product_d;

   assign in_ready  = ~out_valid_q | out_ready;
   assign out_valid = out_valid_q;
   assign product   = product_q;

   // Stage 1: unpack, classify, exponent sum, significand product
   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [PW-1:0]    ma_ext, mb_ext;

   assign {sa, ea, ma} = float_a;
   assign {sb, eb, mb} = float_b;
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (&ea) & ~(|ma);
   assign b_inf  = (&eb) & ~(|mb);
   assign a_nan  = (&ea) & (|ma);
   assign b_nan  = (&eb) & (|mb);
   assign ma_ext = {{(PW - MAN_W - 1){1'b0}}, 1'b1, ma};
   assign mb_ext = {{(PW - MAN_W - 1){1'b0}}, 1'b1, mb};

   logic                  s1_sign_d, s1_nan_d, s1_inf_d, s1_zero_d;
   logic signed [EW2-1:0] s1_exp_d;
   logic [PW-1:0]         s1_frac_d;

   assign s1_sign_d = sa ^ sb;
   assign s1_nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
   assign s1_inf_d  = a_inf | b_inf;
   assign s1_zero_d = a_zero | b_zero;
   assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
   assign s1_frac_d = ma_ext * mb_ext;

   logic                  s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
   logic signed [EW2-1:0] s1_exp_q;
   logic [PW-1:0]         s1_frac_q;

   // Stage 2: normalise by at most one place, then round to nearest even
   logic             msb, guard, sticky;
   logic [MAN_W-1:0] mant;
   logic [MAN_W:0]   mant_r;
   logic signed [EW2-1:0] exp_inc, s2_exp_d;

   assign msb     = s1_frac_q[PW-1];
   assign mant    = msb ? s1_frac_q[2*MAN_W:MAN_W+1] : s1_frac_q[2*MAN_W-1:MAN_W];
   assign guard   = msb ? s1_frac_q[MAN_W] : s1_frac_q[MAN_W-1];
   assign sticky  = (|s1_frac_q[MAN_W-2:0]) | (msb & s1_frac_q[MAN_W-1]);
   assign mant_r  = round_rne(mant, guard, sticky);
   assign exp_inc = EW2'(msb) + EW2'(mant_r[MAN_W]);
   assign s2_exp_d = s1_exp_q + exp_inc;

   logic                  s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
   logic signed [EW2-1:0] s2_exp_q;
   logic [MAN_W-1:0]      s2_man_q;

   // Stage 3: exception priority select and pack
   logic special, exp_nonpos, hit_ovf, hit_unf;

   assign special    = s2_nan_q | s2_inf_q | s2_zero_q;
   assign exp_nonpos = s2_exp_q[EW2-1] | (s2_exp_q == EW2'(0));
   assign hit_ovf    = ~special & ~s2_exp_q[EW2-1] & (s2_exp_q >= EXP_MAX);
   assign hit_unf    = ~special & exp_nonpos;

   always_comb begin
      product_d = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_man_q};
      if (s2_nan_q) begin
         product_d = QNAN;
      end else if (s2_inf_q || hit_ovf) begin
         product_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (s2_zero_q || hit_unf) begin
         product_d = {s2_sign_q, {(W - 1){1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (in_ready) begin
         s1_sign_q <= s1_sign_d;
         s1_nan_q  <= s1_nan_d;
         s1_inf_q  <= s1_inf_d;
         s1_zero_q <= s1_zero_d;
         s1_exp_q  <= s1_exp_d;
         s1_frac_q <= s1_frac_d;
         s2_sign_q <= s1_sign_q;
         s2_nan_q  <= s1_nan_q;
         s2_inf_q  <= s1_inf_q;
         s2_zero_q <= s1_zero_q;
         s2_exp_q  <= s2_exp_d;
         s2_man_q  <= mant_r[MAN_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         out_valid_q <= 1'b0;
         product_q   <= '0;
      end else if (in_ready) begin
         s1_vld_q    <= in_valid;
         s2_vld_q    <= s1_vld_q;
         out_valid_q <= s2_vld_q;
         if (s2_vld_q) begin
            product_q <= product_d;
         end
      end
   end

`ifdef FP_MULT_FLAGS_EN
   logic       s2_inx_q;
   logic [3:0] flags_q, flags_d;

   always_ff @(posedge clk) begin
      if (in_ready) begin
         s2_inx_q <= guard | sticky;
      end
   end

   assign flags_d = {s2_nan_q, hit_ovf, hit_unf,
                     (~special & s2_inx_q) | hit_ovf | hit_unf};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (in_ready && s2_vld_q) begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe (FP16): directed vectors, backpressure, reset, and random traffic vs an integer reference model.
module tb_fp_mult_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] float_a;
   logic [15:0] float_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
`ifdef FP_MULT_FLAGS_EN
   logic [3:0]  flags;
`endif

   fp_mult_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .float_a   (float_a),
      .float_b   (float_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
`ifdef FP_MULT_FLAGS_EN
      ,
      .flags     (flags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] prod;
      logic [3:0]  flg;
   } exp_t;

   exp_t exp_q[$];
   exp_t pend;
   int   checks  = 0;
   int   errors  = 0;
   int   emitted = 0;
   bit   acc;

   // Reference: exact integer product of the significands, rounded to 11 significant bits.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t   r;
      int     ea, eb, e, len, sh;
      longint p, q, rem, half, unit;
      logic   s, az, bz, ai, bi, an, bn;
      s  = a[15] ^ b[15];
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      az = (ea == 0);
      bz = (eb == 0);
      ai = (ea == 31) && (a[9:0] == 10'd0);
      an = (ea == 31) && (a[9:0] != 10'd0);
      bi = (eb == 31) && (b[9:0] == 10'd0);
      bn = (eb == 31) && (b[9:0] != 10'd0);
      r.flg = 4'b0000;
      if (an || bn || (ai && bz) || (bi && az)) begin
         r.prod = 16'h7E00;
         r.flg  = 4'b1000;
         return r;
      end
      if (ai || bi) begin
         r.prod = {s, 15'h7C00};
         return r;
      end
      if (az || bz) begin
         r.prod = {s, 15'h0000};
         return r;
      end
      p    = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
      len  = (p >= 2097152) ? 22 : 21;
      sh   = len - 11;
      unit = longint'(1) << sh;
      q    = p / unit;
      rem  = p % unit;
      half = unit / 2;
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      e = (ea - 15) + (eb - 15) + (len - 21) + 15;
      if (q == 2048) begin
         q = 1024;
         e = e + 1;
      end
      if (e >= 31) begin
         r.prod = {s, 15'h7C00};
         r.flg  = 4'b0101;
      end else if (e <= 0) begin
         r.prod = {s, 15'h0000};
         r.flg  = 4'b0011;
      end else begin
         r.prod = {s, 5'(e), 10'(q - 1024)};
         r.flg  = (rem != 0) ? 4'b0001 : 4'b0000;
      end
      return r;
   endfunction

   function automatic logic [15:0] rand_op();
      int          cls;
      logic [4:0]  e;
      logic [9:0]  m;
      cls = int'($urandom_range(0, 15));
      m   = 10'($urandom);
      if (cls == 0)      e = 5'd0;
      else if (cls == 1) begin
         e = 5'd31;
         if ($urandom_range(0, 1) == 0) m = 10'd0;
      end else           e = 5'($urandom_range(1, 30));
      return {1'($urandom), e, m};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // One clock: settle, score any transfer out, log any accept, then step past the edge.
   task automatic cycle(output bit accepted);
      bit   emit;
      exp_t item;
      #1;
      accepted = (in_valid === 1'b1) && (in_ready === 1'b1);
      emit     = (out_valid === 1'b1) && (out_ready === 1'b1);
      if (emit) begin
         emitted++;
         check("unexpected_output", (exp_q.size() == 0) ? 32'd1 : 32'd0, 32'd0);
         if (exp_q.size() != 0) begin
            item = exp_q.pop_front();
            check("product", {16'd0, product}, {16'd0, item.prod});
`ifdef FP_MULT_FLAGS_EN
            check("flags", {28'd0, flags}, {28'd0, item.flg});
`endif
         end
      end
      if (accepted) exp_q.push_back(pend);
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [15:0] a, input logic [15:0] b);
      float_a = a;
      float_b = b;
      pend    = model(a, b);
   endtask

   task automatic drain();
      bit a_unused;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(a_unused);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   logic [15:0] dir_a [11] = '{16'h3E00, 16'hC000, 16'h3C01, 16'h3C01, 16'h7BFF, 16'h0400,
                               16'h8400, 16'h7C00, 16'hFC00, 16'h7E01, 16'h0001};
   logic [15:0] dir_b [11] = '{16'h4000, 16'h3800, 16'h3C01, 16'h3E00, 16'h7BFF, 16'h3800,
                               16'h3800, 16'h0000, 16'h4000, 16'h3C00, 16'h4000};
   logic [15:0] dir_p [11] = '{16'h4200, 16'hBC00, 16'h3C02, 16'h3E02, 16'h7C00, 16'h0000,
                               16'h8000, 16'h7E00, 16'hFC00, 16'h7E00, 16'h0000};
   logic [15:0] bp_a [8];
   logic [15:0] bp_b [8];
   logic [15:0] held;
   int          idx;
   int          start;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      float_a   = '0;
      float_b   = '0;
      pend      = model(16'h0, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_product", {16'd0, product}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef FP_MULT_FLAGS_EN
      check("rst_flags", {28'd0, flags}, 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency from accept to out_valid
      set_op(16'h3E00, 16'h4000);
      pend.prod = 16'h4200;
      in_valid  = 1'b1;
      cycle(acc);
      check("lat_accept", {31'd0, acc}, 32'd1);
      check("lat_edge1", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;
      cycle(acc);
      check("lat_edge2", {31'd0, out_valid}, 32'd0);
      cycle(acc);
      check("lat_edge3", {31'd0, out_valid}, 32'd1);
      check("lat_product", {16'd0, product}, 32'h4200);
      drain();

      // Directed vectors, back to back; expected products are fixed values
      for (int i = 0; i < 11; i++) begin
         set_op(dir_a[i], dir_b[i]);
         pend.prod = dir_p[i];
         in_valid  = 1'b1;
         cycle(acc);
      end
      drain();

      // Backpressure: 8 back-to-back pairs with a 5-cycle stall in the middle
      for (int i = 0; i < 8; i++) begin
         bp_a[i] = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
         bp_b[i] = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
      end
      start = emitted;
      idx   = 0;
      held  = '0;
      for (int cyc = 0; cyc < 60 && (idx < 8 || exp_q.size() != 0); cyc++) begin
         out_ready = !(cyc >= 6 && cyc < 11);
         if (idx < 8) begin
            set_op(bp_a[idx], bp_b[idx]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc >= 6 && cyc < 11) begin
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            if (cyc == 6) held = product;
            else check("bp_product_stable", {16'd0, product}, {16'd0, held});
         end
         cycle(acc);
         if (acc) idx++;
      end
      check("bp_delivered", 32'(emitted - start), 32'd8);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset with two operations in flight
      out_ready = 1'b0;
      set_op(16'h4000, 16'h4000);
      in_valid = 1'b1;
      cycle(acc);
      set_op(16'h3C00, 16'h4400);
      cycle(acc);
      in_valid = 1'b0;
      cycle(acc);
      check("inflight_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_product", {16'd0, product}, 32'd0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(acc);
         check("no_stale_output", {31'd0, out_valid}, 32'd0);
      end
      set_op(16'hC000, 16'h3800);
      pend.prod = 16'hBC00;
      in_valid  = 1'b1;
      cycle(acc);
      check("post_rst_accept", {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
      cycle(acc);
      check("post_rst_edge2", {31'd0, out_valid}, 32'd0);
      cycle(acc);
      check("post_rst_edge3", {31'd0, out_valid}, 32'd1);
      check("post_rst_product", {16'd0, product}, 32'hBC00);
      drain();

      // Random traffic with random bubbles and backpressure
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         set_op(rand_op(), rand_op());
         cycle(acc);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
